rtf65002_icache_loader: RTL and testbench

Instruction-cache line-fill controller that sits directly upstream of the icache tag memory and the icache data RAM.
- Watches the tag memory's registered hit0/hit1 results for the current fetch address.
- On a miss, runs a 4-beat 32-bit Wishbone incrementing burst to fetch the 16-byte line.
- Writes each beat into the cache through a shared write port (wr/adr/dat); the final beat also carries the tag-valid bit.
- Stalls the fetch stage via busy_o until the new tag is readable.

---
 rtl/rtf65002_pkg.sv | 35 +++
 rtl/rtf65002_icache_loader.sv | 170 +++++++++++++++++
 tb/tb_rtf65002_icache_loader.sv | 340 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rtf65002_pkg.sv
// Shared definitions for the rtf65002 instruction-cache line-fill logic.
//   state_t     : fill controller states (IDLE, LOAD, SETTLE)
//   CTI_*       : Wishbone cycle-type codes used by the burst
//   LINE_WORDS  : 32-bit words per 16-byte cache line
//   bus_adr()   : Wishbone byte address of word widx within a line
//   cache_adr() : cache write address; bit 0 carries the tag-valid bit
package rtf65002_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_W     = 28;
    localparam int unsigned WIDX_W     = 2;

    localparam logic [2:0] CTI_INCR = 3'b010;
    localparam logic [2:0] CTI_EOB  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Byte address of a word within the line on the 34-bit bus.
    function automatic logic [33:0] bus_adr(input logic [LINE_W-1:0] fline,
                                            input logic [WIDX_W-1:0] widx);
        return {2'b00, fline, widx, 2'b00};
    endfunction

    // Cache write address; the tag memory only captures when [3:2]==11,
    // which is also the only beat that sets the valid bit in bit 0.
    function automatic logic [33:0] cache_adr(input logic [LINE_W-1:0] fline,
                                              input logic [WIDX_W-1:0] widx);
        return {2'b00, fline, widx, 1'b0, widx == WIDX_W'(LINE_WORDS - 1)};
    endfunction

endpackage

// File: rtl/rtf65002_icache_loader.sv
// Instruction-cache line-fill controller.
// Watches the tag memory hit results for the registered fetch address and,
// on a miss, fetches the 16-byte line with a 4-beat Wishbone incrementing
// burst, writing each beat into the cache through a shared write port.
// The fetch stage is stalled (busy_o) until the new tag is readable.
// Ports:
//   clk_i, rst_i         : clock, asynchronous active-high reset
//   ic_en_i              : cache enable; 0 suppresses new fills
//   pc_i, hit0_i, hit1_i : fetch address and tag hits for rpc / rpc+8
//   busy_o               : fill in progress
//   cyc_o..adr_o, ack_i, err_i, dat_i : Wishbone master (burst reads)
//   ic_wr_o, ic_adr_o, ic_dat_o       : cache write port
//   bus_err_o            : one-cycle pulse when a fill is aborted by err_i
module rtf65002_icache_loader
    import rtf65002_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ic_en_i,
    input  logic [31:0] pc_i,
    input  logic        hit0_i,
    input  logic        hit1_i,
    output logic        busy_o,
    output logic        cyc_o,
    output logic        stb_o,
    output logic [2:0]  cti_o,
    output logic [1:0]  bte_o,
    output logic [3:0]  sel_o,
    output logic [33:0] adr_o,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic [31:0] dat_i,
    output logic        ic_wr_o,
    output logic [33:0] ic_adr_o,
    output logic [31:0] ic_dat_o,
    output logic        bus_err_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDX_W-1:0] LAST_WORD   = WIDX_W'(LINE_WORDS - 1);

    state_t             state;
    logic [31:0]        rpc;
    logic [31:0]        rpcp8;
    logic               rpc_v;
    logic [LINE_W-1:0]  fill_line;
    logic [WIDX_W-1:0]  widx;
    logic [WIDX_W-1:0]  widx_nx;
    logic [LINE_W-1:0]  miss_line;
    logic               miss;
    logic [CNT_W-1:0]   settle_cnt;

    // Low address bits only select bytes within a line; the fill ignores them.
    logic unused_rpc_lo;
    assign unused_rpc_lo = ^{rpc[3:0], rpcp8[3:0]};

    // Only linear bursts are issued.
    assign bte_o = 2'b00;

    assign widx_nx = widx + WIDX_W'(1);

    // Line to fetch: a hit0 miss wins; a pending hit1 miss is seen again
    // after the fill settles.
    assign miss      = ic_en_i && rpc_v && !(hit0_i && hit1_i);
    assign miss_line = !hit0_i ? rpc[31:4] : rpcp8[31:4];

    // Registered copies of the fetch address, aligned with the tag RAM's
    // registered hit outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin : align
        if (rst_i) begin
            rpc   <= '0;
            rpcp8 <= '0;
        end else begin
            rpc   <= pc_i;
            rpcp8 <= pc_i + 32'd8;
        end
    end

    // Fill FSM with registered bus and cache-write outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin : fsm
        if (rst_i) begin
            state      <= ST_IDLE;
            rpc_v      <= 1'b0;
            fill_line  <= '0;
            widx       <= '0;
            settle_cnt <= '0;
            busy_o     <= 1'b0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            cti_o      <= 3'b000;
            sel_o      <= 4'h0;
            adr_o      <= '0;
            ic_wr_o    <= 1'b0;
            ic_adr_o   <= '0;
            ic_dat_o   <= '0;
            bus_err_o  <= 1'b0;
        end else begin
            ic_wr_o   <= 1'b0;
            bus_err_o <= 1'b0;
            rpc_v     <= 1'b1;

            unique case (state)
                ST_IDLE: begin
                    if (miss) begin
                        state     <= ST_LOAD;
                        busy_o    <= 1'b1;
                        fill_line <= miss_line;
                        widx      <= '0;
                        cyc_o     <= 1'b1;
                        stb_o     <= 1'b1;
                        sel_o     <= 4'hF;
                        cti_o     <= CTI_INCR;
                        adr_o     <= bus_adr(miss_line, '0);
                    end
                end

                ST_LOAD: begin
                    if (err_i) begin
                        // Abort: the erroring beat is not written, so the
                        // tag never becomes valid.
                        cyc_o      <= 1'b0;
                        stb_o      <= 1'b0;
                        sel_o      <= 4'h0;
                        cti_o      <= 3'b000;
                        bus_err_o  <= 1'b1;
                        settle_cnt <= '0;
                        state      <= ST_SETTLE;
                    end else if (ack_i) begin
                        ic_wr_o  <= 1'b1;
                        ic_dat_o <= dat_i;
                        ic_adr_o <= cache_adr(fill_line, widx);
                        widx     <= widx_nx;
                        if (widx == LAST_WORD) begin
                            cyc_o      <= 1'b0;
                            stb_o      <= 1'b0;
                            sel_o      <= 4'h0;
                            cti_o      <= 3'b000;
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end else begin
                            adr_o <= bus_adr(fill_line, widx_nx);
                            cti_o <= (widx_nx == LAST_WORD) ? CTI_EOB : CTI_INCR;
                        end
                    end
                end

                ST_SETTLE: begin
                    // Wait for the written tag to come back through the
                    // tag RAM's synchronous read before trusting hits again.
                    if (settle_cnt == SETTLE_LAST) begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                        rpc_v  <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtf65002_icache_loader.sv
// Directed self-checking bench for rtf65002_icache_loader.
module tb_rtf65002_icache_loader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ic_en_i = 1'b1;
    logic [31:0] pc_i = '0;
    logic        hit0_i = 1'b1;
    logic        hit1_i = 1'b1;
    logic        busy_o, cyc_o, stb_o;
    logic [2:0]  cti_o;
    logic [1:0]  bte_o;
    logic [3:0]  sel_o;
    logic [33:0] adr_o;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic [31:0] dat_i = '0;
    logic        ic_wr_o;
    logic [33:0] ic_adr_o;
    logic [31:0] ic_dat_o;
    logic        bus_err_o;

    int passes = 0;
    int checks = 0;

    // Bus transaction record (written only by serve)
    logic [33:0] adr_q[$];
    logic [2:0]  cti_q[$];
    bit          hold_ok;
    bit          sel_ok;

    // Cache write and cyc logs (written only by the monitor)
    logic [33:0] wr_adr_q[$];
    logic [31:0] wr_dat_q[$];
    int          cyc_cnt = 0;

    rtf65002_icache_loader #(.SETTLE_CYCLES(3)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .ic_en_i(ic_en_i), .pc_i(pc_i),
        .hit0_i(hit0_i), .hit1_i(hit1_i), .busy_o(busy_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .cti_o(cti_o), .bte_o(bte_o),
        .sel_o(sel_o), .adr_o(adr_o), .ack_i(ack_i), .err_i(err_i),
        .dat_i(dat_i), .ic_wr_o(ic_wr_o), .ic_adr_o(ic_adr_o),
        .ic_dat_o(ic_dat_o), .bus_err_o(bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (ic_wr_o) begin
            wr_adr_q.push_back(ic_adr_o);
            wr_dat_q.push_back(ic_dat_o);
        end
        if (cyc_o) cyc_cnt = cyc_cnt + 1;
    end

    // Present a fetch address, let rpc settle, then report the tag results.
    task automatic start_fill(input logic [31:0] pc, input logic h0, input logic h1);
        pc_i = pc;
        @(negedge clk_i);
        @(negedge clk_i);
        hit0_i = h0;
        hit1_i = h1;
    endtask

    // Wishbone slave: 'waits' wait states per beat, err on beat err_beat.
    task automatic serve(input int waits, input int err_beat, input int max_beats,
                         output bit timed_out);
        int beat = 0;
        int w = 0;
        int guard = 0;
        logic [33:0] cur = '0;
        adr_q.delete();
        cti_q.delete();
        hold_ok = 1'b1;
        sel_ok  = 1'b1;
        while (beat < max_beats && guard < 200) begin
            @(negedge clk_i);
            guard++;
            ack_i = 1'b0;
            err_i = 1'b0;
            if (cyc_o && stb_o) begin
                if (sel_o !== 4'hF || bte_o !== 2'b00) sel_ok = 1'b0;
                if (w == 0) begin
                    adr_q.push_back(adr_o);
                    cti_q.push_back(cti_o);
                    cur = adr_o;
                end else if (adr_o !== cur) begin
                    hold_ok = 1'b0;
                end
                if (w == waits) begin
                    if (beat == err_beat) err_i = 1'b1;
                    else begin
                        ack_i = 1'b1;
                        dat_i = 32'hA000_0000 + 32'(beat);
                    end
                    beat++;
                    w = 0;
                end else begin
                    w++;
                end
            end
        end
        @(negedge clk_i);
        ack_i = 1'b0;
        err_i = 1'b0;
        timed_out = (guard >= 200);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy_o && n < 60) begin
            @(negedge clk_i);
            n++;
        end
        ok = !busy_o;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        checks++;
        if ({busy_o, cyc_o, stb_o, ic_wr_o, bus_err_o} !== 5'b0) $display("FAIL reset_ctl: got %b expected 00000", {busy_o, cyc_o, stb_o, ic_wr_o, bus_err_o});
        else passes++;
        checks++;
        if ({cti_o, sel_o, adr_o} !== '0) $display("FAIL reset_bus: got cti=%b sel=%h adr=%h expected 0", cti_o, sel_o, adr_o);
        else passes++;
        checks++;
        if ({ic_adr_o, ic_dat_o} !== '0) $display("FAIL reset_cache: got adr=%h dat=%h expected 0", ic_adr_o, ic_dat_o);
        else passes++;
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_miss_hit0();
        logic [33:0] exp_adr [4] = '{34'h1230, 34'h1234, 34'h1238, 34'h123C};
        logic [2:0]  exp_cti [4] = '{3'b010, 3'b010, 3'b010, 3'b111};
        bit to;
        bit ok;
        int base = wr_adr_q.size();
        start_fill(32'h0000_1234, 1'b0, 1'b1);
        serve(0, -1, 4, to);
        hit0_i = 1'b1;
        hit1_i = 1'b1;
        checks++;
        if (to) $display("FAIL hit0_timeout: burst did not complete");
        else passes++;
        checks++;
        if (adr_q.size() != 4) $display("FAIL hit0_beats: got %0d expected 4", adr_q.size());
        else begin
            passes++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (adr_q[i] !== exp_adr[i] || cti_q[i] !== exp_cti[i])
                    $display("FAIL hit0_beat%0d: got adr=%h cti=%b expected adr=%h cti=%b", i, adr_q[i], cti_q[i], exp_adr[i], exp_cti[i]);
                else passes++;
            end
        end
        checks++;
        if (!sel_ok) $display("FAIL hit0_sel: sel_o/bte_o not F/0 during cycle");
        else passes++;
        checks++;
        if (ic_wr_o !== 1'b1 || ic_adr_o !== 34'h123D || cyc_o !== 1'b0)
            $display("FAIL hit0_last_wr: got wr=%b adr=%h cyc=%b expected 1 0123d 0", ic_wr_o, ic_adr_o, cyc_o);
        else passes++;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk_i);
            checks++;
            if (busy_o !== (k < 3)) $display("FAIL hit0_settle%0d: got busy=%b expected %b", k, busy_o, (k < 3));
            else passes++;
        end
        checks++;
        if (wr_adr_q.size() - base != 4 || wr_adr_q[base] !== 34'h1230)
            $display("FAIL hit0_writes: got n=%0d first=%h expected 4 01230", wr_adr_q.size() - base, wr_adr_q[base]);
        else passes++;
        wait_idle(ok);
    endtask

    task automatic test_miss_hit1();
        bit to;
        bit ok;
        int base = wr_adr_q.size();
        start_fill(32'h0000_123C, 1'b1, 1'b0);
        serve(0, -1, 4, to);
        hit1_i = 1'b1;
        wait_idle(ok);
        checks++;
        if (to || !ok || adr_q.size() != 4 || adr_q[0] !== 34'h1240)
            $display("FAIL hit1_adr: got first=%h n=%0d expected 01240 4", adr_q[0], adr_q.size());
        else passes++;
        checks++;
        if (wr_adr_q.size() - base != 4 || wr_adr_q[base + 3] !== 34'h124D)
            $display("FAIL hit1_last_wr: got n=%0d last=%h expected 4 0124d", wr_adr_q.size() - base, wr_adr_q[wr_adr_q.size() - 1]);
        else passes++;
    endtask

    task automatic test_wrap();
        logic [33:0] exp_adr [4] = '{34'h0, 34'h4, 34'h8, 34'hC};
        bit to;
        bit ok;
        int base = wr_adr_q.size();
        start_fill(32'hFFFF_FFFC, 1'b1, 1'b0);
        serve(0, -1, 4, to);
        hit1_i = 1'b1;
        wait_idle(ok);
        checks++;
        if (to || adr_q.size() != 4) $display("FAIL wrap_beats: got %0d expected 4", adr_q.size());
        else begin
            passes++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (adr_q[i] !== exp_adr[i]) $display("FAIL wrap_adr%0d: got %h expected %h", i, adr_q[i], exp_adr[i]);
                else passes++;
            end
        end
        checks++;
        if (wr_adr_q.size() - base != 4 || wr_adr_q[base + 3] !== 34'hD)
            $display("FAIL wrap_last_wr: got n=%0d last=%h expected 4 0000d", wr_adr_q.size() - base, wr_adr_q[wr_adr_q.size() - 1]);
        else passes++;
    endtask

    task automatic test_both_miss();
        bit to;
        bit ok;
        start_fill(32'h0000_1238, 1'b0, 1'b0);
        serve(0, -1, 4, to);
        hit0_i = 1'b1;
        checks++;
        if (to || adr_q.size() != 4 || adr_q[0] !== 34'h1230)
            $display("FAIL both_first: got first=%h n=%0d expected 01230 4", adr_q[0], adr_q.size());
        else passes++;
        serve(0, -1, 4, to);
        hit1_i = 1'b1;
        checks++;
        if (to || adr_q.size() != 4 || adr_q[0] !== 34'h1240 || cti_q[3] !== 3'b111)
            $display("FAIL both_second: got first=%h n=%0d expected 01240 4", adr_q[0], adr_q.size());
        else passes++;
        wait_idle(ok);
    endtask

    task automatic test_wait_states();
        bit to;
        bit ok;
        int base = wr_adr_q.size();
        logic [33:0] exp_wa [4] = '{34'h2000, 34'h2004, 34'h2008, 34'h200D};
        start_fill(32'h0000_2000, 1'b0, 1'b1);
        serve(2, -1, 4, to);
        hit0_i = 1'b1;
        wait_idle(ok);
        checks++;
        if (to || !hold_ok || adr_q.size() != 4) $display("FAIL ws_hold: got hold=%b n=%0d expected 1 4", hold_ok, adr_q.size());
        else passes++;
        checks++;
        if (wr_adr_q.size() - base != 4) $display("FAIL ws_nwr: got %0d expected 4", wr_adr_q.size() - base);
        else begin
            passes++;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_dat_q[base + i] !== 32'hA000_0000 + 32'(i) || wr_adr_q[base + i] !== exp_wa[i])
                    $display("FAIL ws_wr%0d: got adr=%h dat=%h expected adr=%h dat=%h", i, wr_adr_q[base + i], wr_dat_q[base + i], exp_wa[i], 32'hA000_0000 + 32'(i));
                else passes++;
            end
        end
    endtask

    task automatic test_bus_error();
        bit to;
        bit ok;
        bit bad = 1'b0;
        int base = wr_adr_q.size();
        start_fill(32'h0000_1234, 1'b0, 1'b1);
        serve(0, 1, 2, to);
        hit0_i = 1'b1;
        checks++;
        if (to || cyc_o !== 1'b0 || bus_err_o !== 1'b1)
            $display("FAIL err_abort: got cyc=%b bus_err=%b expected 0 1", cyc_o, bus_err_o);
        else passes++;
        @(negedge clk_i);
        checks++;
        if (bus_err_o !== 1'b0) $display("FAIL err_pulse: got %b expected 0", bus_err_o);
        else passes++;
        wait_idle(ok);
        for (int i = base; i < wr_adr_q.size(); i++)
            if (wr_adr_q[i][3:2] == 2'b11) bad = 1'b1;
        checks++;
        if (wr_adr_q.size() - base != 1 || wr_adr_q[base] !== 34'h1230 || bad || !ok)
            $display("FAIL err_writes: got n=%0d first=%h expected 1 01230", wr_adr_q.size() - base, wr_adr_q[base]);
        else passes++;
    endtask

    task automatic test_reset_mid_burst();
        bit to;
        int base = wr_adr_q.size();
        start_fill(32'h0000_1234, 1'b0, 1'b1);
        serve(0, -1, 1, to);
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if (to || cyc_o !== 1'b0 || busy_o !== 1'b0 || ic_wr_o !== 1'b0)
            $display("FAIL rst_async: got cyc=%b busy=%b wr=%b expected 0 0 0", cyc_o, busy_o, ic_wr_o);
        else passes++;
        hit0_i = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (8) @(negedge clk_i);
        checks++;
        if (wr_adr_q.size() - base != 1 || cyc_o !== 1'b0)
            $display("FAIL rst_writes: got n=%0d cyc=%b expected 1 0", wr_adr_q.size() - base, cyc_o);
        else passes++;
    endtask

    task automatic test_disabled();
        int c0 = cyc_cnt;
        ic_en_i = 1'b0;
        start_fill(32'h0000_5670, 1'b0, 1'b0);
        repeat (20) @(negedge clk_i);
        checks++;
        if (cyc_cnt != c0 || busy_o !== 1'b0)
            $display("FAIL en_off: got cyc_cycles=%0d busy=%b expected 0 0", cyc_cnt - c0, busy_o);
        else passes++;
        hit0_i = 1'b1;
        hit1_i = 1'b1;
        ic_en_i = 1'b1;
        repeat (2) @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_miss_hit0();
        test_miss_hit1();
        test_wrap();
        test_both_miss();
        test_wait_states();
        test_bus_error();
        test_reset_mid_burst();
        test_disabled();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
